// File: rtl/simple_proc_gen.sv
// Parametrised multicycle processor: valid/ready instruction fetch,
// separate immediate word, eight-op ALU, zero/negative flags.
module simple_proc_gen #(
    parameter int REG_WIDTH  = 16,
    parameter int NUM_GP_REG = 8,
    localparam int RW = $clog2(NUM_GP_REG),
    localparam int IW = 3 + 2 * RW
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IW-1:0]                   din,
    input  logic                            din_valid,
    output logic                            din_ready,
    output logic [REG_WIDTH-1:0]            bus,
    output logic [NUM_GP_REG*REG_WIDTH-1:0] r_flat,
    output logic [2:0]                      state,
    output logic                            done,
    output logic                            flag_z,
    output logic                            flag_n
);

    localparam logic [2:0] S_FETCH = 3'd0;
    localparam logic [2:0] S_IMM   = 3'd1;
    localparam logic [2:0] S_EX1   = 3'd2;
    localparam logic [2:0] S_EX2   = 3'd3;
    localparam logic [2:0] S_EX3   = 3'd4;

    localparam logic [2:0] OP_MV   = 3'd0;
    localparam logic [2:0] OP_ADD  = 3'd1;
    localparam logic [2:0] OP_ADDI = 3'd2;
    localparam logic [2:0] OP_SUB  = 3'd3;
    localparam logic [2:0] OP_AND  = 3'd4;
    localparam logic [2:0] OP_XOR  = 3'd5;
    localparam logic [2:0] OP_SUBI = 3'd6;
    localparam logic [2:0] OP_MVI  = 3'd7;

    logic [2:0]           state_q, state_d;
    logic [IW-1:0]        ir_q;
    logic [REG_WIDTH-1:0] imm_q;
    logic [REG_WIDTH-1:0] a_q;
    logic [REG_WIDTH-1:0] g_q;
    logic                 z_q;
    logic                 n_q;
    logic [REG_WIDTH-1:0] regs_q [NUM_GP_REG];

    logic [2:0]            op;
    logic [RW-1:0]         rx;
    logic [RW-1:0]         ry;
    logic [2:0]            din_op;
    logic                  din_needs_imm;
    logic                  op_uses_imm;
    logic [REG_WIDTH-1:0]  imm_ext;
    logic [REG_WIDTH-1:0]  alu;
    logic                  ir_en;
    logic                  imm_en;
    logic                  a_en;
    logic                  g_en;
    logic                  wr;
    logic [NUM_GP_REG-1:0] wen;

    assign op = ir_q[IW-1:IW-3];
    assign rx = ir_q[2*RW-1:RW];
    assign ry = ir_q[RW-1:0];

    assign din_op        = din[IW-1:IW-3];
    assign din_needs_imm = (din_op == OP_ADDI) || (din_op == OP_SUBI) ||
                           (din_op == OP_MVI);
    assign op_uses_imm   = (op == OP_ADDI) || (op == OP_SUBI);
    assign imm_ext       = REG_WIDTH'($signed(din));

    assign state  = state_q;
    assign flag_z = z_q;
    assign flag_n = n_q;

    for (genvar gi = 0; gi < NUM_GP_REG; gi++) begin : g_flat
        assign r_flat[gi*REG_WIDTH +: REG_WIDTH] = regs_q[gi];
    end

    // FSM sequencing, bus source selection and strobe generation
    always_comb begin
        state_d   = state_q;
        din_ready = 1'b0;
        done      = 1'b0;
        bus       = '0;
        ir_en     = 1'b0;
        imm_en    = 1'b0;
        a_en      = 1'b0;
        g_en      = 1'b0;
        wr        = 1'b0;
        case (state_q)
            S_FETCH: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    ir_en   = 1'b1;
                    state_d = din_needs_imm ? S_IMM : S_EX1;
                end
            end
            S_IMM: begin
                din_ready = 1'b1;
                if (din_valid) begin
                    imm_en  = 1'b1;
                    state_d = S_EX1;
                end
            end
            S_EX1: begin
                unique case (1'b1)
                    (op == OP_MV): begin
                        bus     = regs_q[ry];
                        wr      = 1'b1;
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                    (op == OP_MVI): begin
                        bus     = imm_q;
                        wr      = 1'b1;
                        done    = 1'b1;
                        state_d = S_FETCH;
                    end
                    default: begin
                        bus     = regs_q[rx];
                        a_en    = 1'b1;
                        state_d = S_EX2;
                    end
                endcase
            end
            S_EX2: begin
                bus     = op_uses_imm ? imm_q : regs_q[ry];
                g_en    = 1'b1;
                state_d = S_EX3;
            end
            S_EX3: begin
                bus     = g_q;
                wr      = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // ALU: A operand against whatever EX2 drives onto the bus
    always_comb begin
        alu = '0;
        case (op)
            OP_ADD, OP_ADDI: alu = a_q + bus;
            OP_SUB, OP_SUBI: alu = a_q - bus;
            OP_AND:          alu = a_q & bus;
            OP_XOR:          alu = a_q ^ bus;
            default:         alu = '0;
        endcase
    end

    // One-hot register write enable for the rx destination
    always_comb begin
        wen = '0;
        if (wr) wen[rx] = 1'b1;
    end

    // Control and datapath registers: state, IR, IMM, A, G, flags
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_FETCH;
            ir_q    <= '0;
            imm_q   <= '0;
            a_q     <= '0;
            g_q     <= '0;
            z_q     <= 1'b0;
            n_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (ir_en)  ir_q  <= din;
            if (imm_en) imm_q <= imm_ext;
            if (a_en)   a_q   <= bus;
            if (g_en) begin
                g_q <= alu;
                z_q <= (alu == '0);
                n_q <= alu[REG_WIDTH-1];
            end
        end
    end

    // General-purpose register file, written from the bus
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_GP_REG; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_GP_REG; i++) begin
                if (wen[i]) regs_q[i] <= bus;
            end
        end
    end

endmodule

// File: tb/tb_simple_proc_gen.sv
// Directed bench for simple_proc_gen: 16/8 instance driven from a vector
// table plus hand sequences, and an 8/4 instance for the narrow config.
module tb_simple_proc_gen;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [8:0]   din = '0;
    logic         din_valid = 1'b0;
    logic         din_ready;
    logic [15:0]  bus;
    logic [127:0] r_flat;
    logic [2:0]   state;
    logic         done, flag_z, flag_n;

    simple_proc_gen #(.REG_WIDTH(16), .NUM_GP_REG(8)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .bus(bus), .r_flat(r_flat),
        .state(state), .done(done), .flag_z(flag_z), .flag_n(flag_n)
    );

    logic [6:0]  din2 = '0;
    logic        dv2 = 1'b0;
    logic        rdy2;
    logic [7:0]  bus2;
    logic [31:0] r_flat2;
    logic [2:0]  state2;
    logic        done2, z2, n2;

    simple_proc_gen #(.REG_WIDTH(8), .NUM_GP_REG(4)) u_dut2 (
        .clk(clk), .rst(rst), .din(din2), .din_valid(dv2),
        .din_ready(rdy2), .bus(bus2), .r_flat(r_flat2),
        .state(state2), .done(done2), .flag_z(z2), .flag_n(n2)
    );

    typedef struct {
        logic [8:0]  w0;
        logic [8:0]  w1;
        int          stall;
        int          rx;
        logic [15:0] val;
        logic        z;
        logic        n;
        int          lat;
    } vec_t;

    vec_t        tv [12];
    logic [15:0] mdl [8];
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] flat();
        logic [127:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) f[i*16 +: 16] = mdl[i];
        return f;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        int cyc;
        int st;
        din = tv[i].w0;
        din_valid = 1'b1;
        tick();
        cyc = 1;
        st = 0;
        while (!done && cyc < 20) begin
            if (state == 3'd1) begin
                if (st < tv[i].stall) begin
                    din_valid = 1'b0;
                    st++;
                    tick();
                    cyc++;
                    chk($sformatf("v%0d_stall_state", i), 128'(state), 128'(3'd1));
                    chk($sformatf("v%0d_stall_rdy", i), 128'(din_ready), 128'(1'b1));
                    chk($sformatf("v%0d_stall_regs", i), r_flat, flat());
                    if (i > 0)
                        chk($sformatf("v%0d_stall_flags", i),
                            128'({flag_z, flag_n}),
                            128'({tv[i-1].z, tv[i-1].n}));
                    continue;
                end
                din = tv[i].w1;
                din_valid = 1'b1;
            end else begin
                din_valid = 1'b0;
            end
            tick();
            cyc++;
        end
        din_valid = 1'b0;
        chk($sformatf("v%0d_done", i), 128'(done), 128'(1'b1));
        chk($sformatf("v%0d_latency", i), 128'(cyc), 128'(tv[i].lat));
        mdl[tv[i].rx] = tv[i].val;
        tick();
        chk($sformatf("v%0d_regs", i), r_flat, flat());
        chk($sformatf("v%0d_flags", i), 128'({flag_z, flag_n}),
            128'({tv[i].z, tv[i].n}));
        chk($sformatf("v%0d_done_low", i), 128'(done), 128'(1'b0));
        chk($sformatf("v%0d_fetch", i), 128'(state), 128'(3'd0));
    endtask

    task automatic run2(input string nm, input logic [6:0] w0,
                        input logic [6:0] w1, input logic [31:0] exp_flat,
                        input logic ez, input logic en);
        int cyc;
        din2 = w0;
        dv2 = 1'b1;
        tick();
        cyc = 1;
        while (!done2 && cyc < 20) begin
            if (state2 == 3'd1) din2 = w1;
            else dv2 = 1'b0;
            tick();
            cyc++;
        end
        dv2 = 1'b0;
        chk({nm, "_done"}, 128'(done2), 128'(1'b1));
        tick();
        chk({nm, "_regs"}, 128'(r_flat2), 128'(exp_flat));
        chk({nm, "_flags"}, 128'({z2, n2}), 128'({ez, en}));
    endtask

    initial begin
        tv[0]  = '{9'h1C0, 9'h005, 0, 0, 16'h0005, 1'b0, 1'b0, 2};
        tv[1]  = '{9'h1C8, 9'h1FF, 0, 1, 16'hFFFF, 1'b0, 1'b0, 2};
        tv[2]  = '{9'h041, 9'h000, 0, 0, 16'h0004, 1'b0, 1'b0, 3};
        tv[3]  = '{9'h0C0, 9'h000, 0, 0, 16'h0000, 1'b1, 1'b0, 3};
        tv[4]  = '{9'h180, 9'h001, 0, 0, 16'hFFFF, 1'b0, 1'b1, 4};
        tv[5]  = '{9'h011, 9'h000, 0, 2, 16'hFFFF, 1'b0, 1'b1, 1};
        tv[6]  = '{9'h1D8, 9'h0F0, 0, 3, 16'h00F0, 1'b0, 1'b1, 2};
        tv[7]  = '{9'h11A, 9'h000, 0, 3, 16'h00F0, 1'b0, 1'b0, 3};
        tv[8]  = '{9'h153, 9'h000, 0, 2, 16'hFF0F, 1'b0, 1'b1, 3};
        tv[9]  = '{9'h098, 9'h110, 0, 3, 16'h0000, 1'b1, 1'b0, 4};
        tv[10] = '{9'h198, 9'h100, 3, 3, 16'h0100, 1'b0, 1'b0, 7};
        tv[11] = '{9'h064, 9'h000, 0, 4, 16'h0000, 1'b1, 1'b0, 3};
        for (int i = 0; i < 8; i++) mdl[i] = '0;

        #12;
        chk("rst_state", 128'(state), 128'(3'd0));
        chk("rst_rdy", 128'(din_ready), 128'(1'b1));
        chk("rst_done_bus", 128'({done, bus}), 128'(17'h0));
        chk("rst_regs", r_flat, 128'h0);
        chk("rst_flags", 128'({flag_z, flag_n}), 128'(2'b00));
        rst = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(i);

        // back-to-back MV R5,R2 then MV R6,R5 with valid held high
        din = 9'h02A;
        din_valid = 1'b1;
        tick();
        chk("b2b_done1", 128'(done), 128'(1'b1));
        chk("b2b_rdy_ex1", 128'(din_ready), 128'(1'b0));
        chk("b2b_bus_ex1", 128'(bus), 128'(16'hFF0F));
        din = 9'h035;
        tick();
        chk("b2b_fetch", 128'({state, din_ready}), 128'({3'd0, 1'b1}));
        tick();
        din_valid = 1'b0;
        chk("b2b_done2", 128'(done), 128'(1'b1));
        tick();
        mdl[5] = 16'hFF0F;
        mdl[6] = 16'hFF0F;
        chk("b2b_regs", r_flat, flat());

        // narrow configuration: 8-bit registers, four of them
        run2("n_mvi_r3", 7'h7C, 7'h7F, 32'hFF00_0000, 1'b0, 1'b0);
        run2("n_mvi_r1", 7'h74, 7'h40, 32'hFF00_C000, 1'b0, 1'b0);
        run2("n_xor_r3", 7'h5F, 7'h00, 32'h0000_C000, 1'b1, 1'b0);

        // asynchronous reset in EX2 of ADD R1,R2
        din = 9'h04A;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        chk("ar_in_ex2", 128'(state), 128'(3'd3));
        #2 rst = 1'b0;
        #1;
        chk("ar_state", 128'(state), 128'(3'd0));
        chk("ar_regs", r_flat, 128'h0);
        chk("ar_bus_done", 128'({bus, done}), 128'(17'h0));
        chk("ar_flags", 128'({flag_z, flag_n}), 128'(2'b00));
        chk("ar_rdy", 128'(din_ready), 128'(1'b1));
        @(posedge clk);
        #2 rst = 1'b1;
        tick();
        chk("ar_after", 128'({state, din_ready}), 128'({3'd0, 1'b1}));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
